// File: rtl/gfau_point_add_seq_if.sv
// GFAU request/response bus. The point-add sequencer is the master; the
// GF(p) arithmetic unit answering the requests is the slave.
interface gfau_point_add_seq_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] o_gfau_in_0;
    logic [SIZE-1:0] o_gfau_in_1;
    logic [SIZE-1:0] o_gfau_prime;
    logic [1:0]      o_gfau_op;
    logic            o_gfau_start;
    logic            i_gfau_done;
    logic [SIZE-1:0] i_gfau_result;

    modport master (
        output o_gfau_in_0, o_gfau_in_1, o_gfau_prime, o_gfau_op, o_gfau_start,
        input  i_gfau_done, i_gfau_result
    );

    modport slave (
        input  o_gfau_in_0, o_gfau_in_1, o_gfau_prime, o_gfau_op, o_gfau_start,
        output i_gfau_done, i_gfau_result
    );
endinterface

// File: rtl/gfau_point_add_seq.sv
// Affine elliptic-curve point addition P3 = P1 + P2 sequenced over an external
// GFAU. A fixed nine-step microprogram issues one field operation at a time;
// this block itself only compares, counts and steers operands.
module gfau_point_add_seq #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [SIZE-1:0]       i_x1,
    input  logic [SIZE-1:0]       i_y1,
    input  logic [SIZE-1:0]       i_x2,
    input  logic [SIZE-1:0]       i_y2,
    input  logic [SIZE-1:0]       i_prime,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_err,
    output logic [SIZE-1:0]       o_x3,
    output logic [SIZE-1:0]       o_y3,
    gfau_point_add_seq_if.master  m_gfau
);
    // Timeout counter runs 0..TIMEOUT-1 while waiting on a single response.
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_EQX = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t           r_state, w_state_n;
    logic [3:0]       r_step, w_step_n;
    logic [TMO_W-1:0] r_tmo;

    // Latched operands and microprogram temporaries.
    logic [SIZE-1:0]  r_x1, r_y1, r_x2, r_y2, r_prime;
    logic [SIZE-1:0]  r_t0, r_t1, r_l, r_t2, r_x3, r_t3;
    logic [SIZE-1:0]  w_x1_n, w_y1_n, w_x2_n, w_y2_n, w_prime_n;
    logic [SIZE-1:0]  w_t0_n, w_t1_n, w_l_n, w_t2_n, w_x3_n, w_t3_n;

    // GFAU launch registers and the operand selection feeding them.
    logic [1:0]       r_gfau_op, w_op;
    logic [SIZE-1:0]  r_gfau_in_0, r_gfau_in_1, r_gfau_prime;
    logic [SIZE-1:0]  w_in_0, w_in_1;

    logic [SIZE-1:0]  r_x3_out, r_y3_out;
    logic [1:0]       r_err;

    logic             w_same_x, w_accept, w_resp, w_last, w_tmo_hit;

    assign w_same_x  = (i_x1 == i_x2);
    assign w_accept  = (r_state == S_IDLE) && i_start;
    assign w_resp    = (r_state == S_WAIT) && m_gfau.i_gfau_done;
    assign w_last    = (r_step == 4'd8);
    assign w_tmo_hit = (r_state == S_WAIT) && !m_gfau.i_gfau_done
                       && (r_tmo == TMO_W'(TIMEOUT - 1));

    assign m_gfau.o_gfau_op    = r_gfau_op;
    assign m_gfau.o_gfau_in_0  = r_gfau_in_0;
    assign m_gfau.o_gfau_in_1  = r_gfau_in_1;
    assign m_gfau.o_gfau_prime = r_gfau_prime;

    assign o_err = r_err;
    assign o_x3  = r_x3_out;
    assign o_y3  = r_y3_out;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    // Next-state logic: equal x short-circuits to FIN, timeout aborts a wait.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_n = w_same_x ? S_FIN : S_ISSUE;
            S_ISSUE: w_state_n = S_WAIT;
            S_WAIT: begin
                if (w_resp)         w_state_n = w_last ? S_FIN : S_ISSUE;
                else if (w_tmo_hit) w_state_n = S_FIN;
            end
            S_FIN:   w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        o_busy              = (r_state != S_IDLE);
        o_done              = (r_state == S_FIN);
        m_gfau.o_gfau_start = (r_state == S_ISSUE);
    end

    // Next values of step and register file: a response is only accepted in WAIT.
    always_comb begin
        w_step_n  = r_step;
        w_x1_n    = r_x1;
        w_y1_n    = r_y1;
        w_x2_n    = r_x2;
        w_y2_n    = r_y2;
        w_prime_n = r_prime;
        w_t0_n    = r_t0;
        w_t1_n    = r_t1;
        w_l_n     = r_l;
        w_t2_n    = r_t2;
        w_x3_n    = r_x3;
        w_t3_n    = r_t3;
        if (w_accept && !w_same_x) begin
            w_step_n  = 4'd0;
            w_x1_n    = i_x1;
            w_y1_n    = i_y1;
            w_x2_n    = i_x2;
            w_y2_n    = i_y2;
            w_prime_n = i_prime;
        end
        if (w_resp) begin
            if (!w_last) w_step_n = r_step + 4'd1;
            case (r_step)
                4'd0:       w_t0_n = m_gfau.i_gfau_result;
                4'd1:       w_t1_n = m_gfau.i_gfau_result;
                4'd2:       w_l_n  = m_gfau.i_gfau_result;
                4'd3, 4'd4: w_t2_n = m_gfau.i_gfau_result;
                4'd5:       w_x3_n = m_gfau.i_gfau_result;
                4'd6, 4'd7: w_t3_n = m_gfau.i_gfau_result;
                default:    ;
            endcase
        end
    end

    // Operand selection for the step about to be issued, using the values the
    // registers will hold after this edge so a fresh result feeds straight in.
    always_comb begin
        w_op   = OP_ADD;
        w_in_0 = '0;
        w_in_1 = '0;
        case (w_step_n)
            4'd0: begin w_op = OP_SUB; w_in_0 = w_y2_n; w_in_1 = w_y1_n; end
            4'd1: begin w_op = OP_SUB; w_in_0 = w_x2_n; w_in_1 = w_x1_n; end
            4'd2: begin w_op = OP_DIV; w_in_0 = w_t0_n; w_in_1 = w_t1_n; end
            4'd3: begin w_op = OP_MUL; w_in_0 = w_l_n;  w_in_1 = w_l_n;  end
            4'd4: begin w_op = OP_SUB; w_in_0 = w_t2_n; w_in_1 = w_x1_n; end
            4'd5: begin w_op = OP_SUB; w_in_0 = w_t2_n; w_in_1 = w_x2_n; end
            4'd6: begin w_op = OP_SUB; w_in_0 = w_x1_n; w_in_1 = w_x3_n; end
            4'd7: begin w_op = OP_MUL; w_in_0 = w_l_n;  w_in_1 = w_t3_n; end
            4'd8: begin w_op = OP_SUB; w_in_0 = w_t3_n; w_in_1 = w_y1_n; end
            default: ;
        endcase
    end

    // Step and timeout counters; the timeout count restarts with every issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_step <= '0;
            r_tmo  <= '0;
        end else begin
            r_step <= w_step_n;
            if (r_state == S_ISSUE)
                r_tmo <= '0;
            else if ((r_state == S_WAIT) && !m_gfau.i_gfau_done)
                r_tmo <= r_tmo + 1'b1;
        end
    end

    // Operand latches and microprogram temporaries.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x1    <= '0;
            r_y1    <= '0;
            r_x2    <= '0;
            r_y2    <= '0;
            r_prime <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_l     <= '0;
            r_t2    <= '0;
            r_x3    <= '0;
            r_t3    <= '0;
        end else begin
            r_x1    <= w_x1_n;
            r_y1    <= w_y1_n;
            r_x2    <= w_x2_n;
            r_y2    <= w_y2_n;
            r_prime <= w_prime_n;
            r_t0    <= w_t0_n;
            r_t1    <= w_t1_n;
            r_l     <= w_l_n;
            r_t2    <= w_t2_n;
            r_x3    <= w_x3_n;
            r_t3    <= w_t3_n;
        end
    end

    // GFAU request registers: loaded on entry to ISSUE, held until the next issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gfau_op    <= OP_ADD;
            r_gfau_in_0  <= '0;
            r_gfau_in_1  <= '0;
            r_gfau_prime <= '0;
        end else if (w_state_n == S_ISSUE) begin
            r_gfau_op    <= w_op;
            r_gfau_in_0  <= w_in_0;
            r_gfau_in_1  <= w_in_1;
            r_gfau_prime <= w_prime_n;
        end
    end

    // Result and status: written only on the edge that enters FIN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x3_out <= '0;
            r_y3_out <= '0;
            r_err    <= ERR_OK;
        end else if (w_accept && w_same_x) begin
            r_x3_out <= '0;
            r_y3_out <= '0;
            r_err    <= ERR_EQX;
        end else if (w_resp && w_last) begin
            r_x3_out <= r_x3;
            r_y3_out <= m_gfau.i_gfau_result;
            r_err    <= ERR_OK;
        end else if (w_tmo_hit) begin
            r_x3_out <= '0;
            r_y3_out <= '0;
            r_err    <= ERR_TMO;
        end
    end
endmodule
